// File: rtl/cursor_controller.sv
// Cursor position register driven by held keys, with typematic auto-repeat on RIGHT/LEFT.
// Steps land at the press edge (count/moved registered); no backpressure, key_valid is level-held.
module cursor_controller #(
  parameter int         WIDTH        = 3,
  parameter int         MAX_POS      = 5,
  parameter int         WRAP         = 0,
  parameter logic [3:0] CODE_RIGHT   = 4'b1111,
  parameter logic [3:0] CODE_LEFT    = 4'b1101,
  parameter logic [3:0] CODE_HOME    = 4'b1110,
  parameter logic [3:0] CODE_END     = 4'b1100,
  parameter int         REPEAT_DELAY = 500,
  parameter int         REPEAT_RATE  = 100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             at_min,
  output logic             at_max,
  output logic             moved
);

  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [WIDTH:0] MAX_EXT  = (WIDTH+1)'(MAX_POS);
  localparam logic [TW-1:0]  DELAY_LD = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]  RATE_LD  = TW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t          state;
  logic [TW-1:0]   timer;
  logic [3:0]      code_q;
  logic            kv_q;
  logic            press;
  logic            rep_fire;
  logic [WIDTH:0]  count_ext;
  logic [WIDTH:0]  target;
  logic [WIDTH:0]  next_count;

  function automatic logic [WIDTH:0] step_pos(input logic [3:0] code, input logic [WIDTH:0] cur);
    step_pos = cur;
    if (code == CODE_RIGHT) begin
      if (cur >= MAX_EXT) step_pos = (WRAP != 0) ? '0 : MAX_EXT;
      else                step_pos = cur + 1'b1;
    end else if (code == CODE_LEFT) begin
      if (cur == '0) step_pos = (WRAP != 0) ? MAX_EXT : '0;
      else           step_pos = cur - 1'b1;
    end else if (code == CODE_HOME) begin
      step_pos = '0;
    end else if (code == CODE_END) begin
      step_pos = MAX_EXT;
    end
  endfunction

  assign count_ext = {1'b0, count};
  assign press     = key_valid & ~kv_q;
  assign at_min    = (count_ext == '0);
  assign at_max    = (count_ext == MAX_EXT);

  // A repeat step only fires while the same key is still held and the timer has run out.
  always_comb begin
    rep_fire = 1'b0;
    if (state != IDLE && key_valid && key_code == code_q && timer == '0)
      rep_fire = 1'b1;
    target     = step_pos(press ? key_code : code_q, count_ext);
    next_count = count_ext;
    if (clear)
      next_count = '0;
    else if (press || rep_fire)
      next_count = target;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= '0;
      moved  <= 1'b0;
      state  <= IDLE;
      timer  <= '0;
      code_q <= '0;
      kv_q   <= 1'b1;
    end else begin
      kv_q  <= key_valid;
      count <= next_count[WIDTH-1:0];
      moved <= (next_count != count_ext);
      if (clear) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (press && (key_code == CODE_RIGHT || key_code == CODE_LEFT)) begin
              state  <= DELAY;
              timer  <= DELAY_LD;
              code_q <= key_code;
            end
          end
          DELAY, REPEAT: begin
            if (!key_valid || key_code != code_q) begin
              state <= IDLE;
            end else if (timer == '0) begin
              state <= REPEAT;
              timer <= RATE_LD;
            end else begin
              timer <= timer - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
